// File: rtl/physics_pkg.sv
// physics_pkg
//   Shared fixed-point widths, the packed object record and the scanner
//   state encoding used by collision_pair_scanner and collision_detector.
//   No ports (package).
package physics_pkg;

    // Fixed-point formats: integer bits / fraction bits / total width
    localparam int POS_I_W   = 7;
    localparam int POS_F_W   = 25;
    localparam int POS_W     = POS_I_W + POS_F_W;
    localparam int VEL_I_W   = 6;
    localparam int VEL_F_W   = 26;
    localparam int VEL_W     = VEL_I_W + VEL_F_W;
    localparam int BASIS_I_W = 2;
    localparam int BASIS_F_W = 14;
    localparam int BASIS_W   = BASIS_I_W + BASIS_F_W;
    localparam int DIM_I_W   = 8;
    localparam int DIM_F_W   = 0;
    localparam int DIM_W     = DIM_I_W + DIM_F_W;

    localparam int OBJ_W = 208;

    // Accumulator width for the separating-axis products in the detector
    localparam int ACC_W = 56;

    typedef struct packed {
        logic signed [POS_W-1:0] x;
        logic signed [POS_W-1:0] y;
    } pos_t;

    typedef struct packed {
        logic signed [VEL_W-1:0] x;
        logic signed [VEL_W-1:0] y;
    } vel_t;

    typedef struct packed {
        logic signed [BASIS_W-1:0] x;
        logic signed [BASIS_W-1:0] y;
    } basis_t;

    // Field order, MSB first: width, height, pos, vel, u, v
    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
        pos_t             pos;
        vel_t             vel;
        basis_t           u;
        basis_t           v;
    } obj_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_REG_A,
        ST_RD_B,
        ST_REG_B,
        ST_CHECK,
        ST_EMIT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/collision_detector.sv
// collision_detector
//   Combinational oriented-box overlap test (separating axis theorem)
//   between two object records. Boxes are centred on pos, with full
//   extents width along u and height along v.
// Ports:
//   obj_a, obj_b  in   object records
//   is_collision  out  1 when no separating axis exists (touching counts)
module collision_detector
    import physics_pkg::*;
(
    input  obj_t obj_a,
    input  obj_t obj_b,
    output logic is_collision
);

    typedef logic signed [ACC_W-1:0] acc_t;

    // Radii are width * |dot| with the half-extent factor folded into the
    // shift: fraction 2*BASIS_F_W + 1, aligned to POS_F_W + BASIS_F_W.
    localparam int R_SHIFT = POS_F_W + BASIS_F_W - 2 * BASIS_F_W - 1;

    function automatic acc_t abs_acc(input acc_t v);
        return v[ACC_W-1] ? -v : v;
    endfunction

    function automatic acc_t dot_basis(input basis_t p, input basis_t q);
        return acc_t'(p.x) * acc_t'(q.x) + acc_t'(p.y) * acc_t'(q.y);
    endfunction

    function automatic acc_t radius(input obj_t o, input basis_t ax);
        acc_t w;
        acc_t h;
        w = acc_t'({1'b0, o.width});
        h = acc_t'({1'b0, o.height});
        return w * abs_acc(dot_basis(o.u, ax)) + h * abs_acc(dot_basis(o.v, ax));
    endfunction

    function automatic logic separated(input acc_t dx, input acc_t dy,
                                       input basis_t ax,
                                       input obj_t a, input obj_t b);
        acc_t proj;
        acc_t rsum;
        proj = dx * acc_t'(ax.x) + dy * acc_t'(ax.y);
        rsum = (radius(a, ax) + radius(b, ax)) <<< R_SHIFT;
        return abs_acc(proj) > rsum;
    endfunction

    acc_t dx;
    acc_t dy;

    always_comb begin
        dx = acc_t'(obj_b.pos.x) - acc_t'(obj_a.pos.x);
        dy = acc_t'(obj_b.pos.y) - acc_t'(obj_a.pos.y);
        is_collision = !(separated(dx, dy, obj_a.u, obj_a, obj_b) ||
                         separated(dx, dy, obj_a.v, obj_a, obj_b) ||
                         separated(dx, dy, obj_b.u, obj_a, obj_b) ||
                         separated(dx, dy, obj_b.v, obj_a, obj_b));
    end

    // Velocity is not part of the geometric test
    logic unused_vel;
    assign unused_vel = ^{obj_a.vel, obj_b.vel};

endmodule

// File: rtl/collision_pair_scanner.sv
// collision_pair_scanner
//   Walks every unordered object pair (i<j) of the object table, feeds each
//   pair to a collision_detector and reports colliding pairs on a
//   valid/ready port, then pulses done.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle scan request (ignored unless idle)
//   num_objects         object count, sampled on accepted start, clamped to N_OBJ
//   obj_rd_addr/_data   object RAM read port (data one cycle after address)
//   hit_valid/_ready    colliding pair handshake, pair on hit_i < hit_j
//   hit_count           hits in current/last scan, saturating
//   busy, done          not idle / one-cycle end-of-scan pulse
// Build option:
//   COLL_SCAN_SKIP_STATIC_EN  pairs whose objects both have zero velocity
//                             are never reported or counted
module collision_pair_scanner
    import physics_pkg::*;
#(
    parameter int N_OBJ = 8,
    parameter int IDX_W = $clog2(N_OBJ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IDX_W:0]   num_objects,
    output logic [IDX_W-1:0] obj_rd_addr,
    input  logic [OBJ_W-1:0] obj_rd_data,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [IDX_W-1:0] hit_i,
    output logic [IDX_W-1:0] hit_j,
    output logic [15:0]      hit_count,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0] N_MAX = (IDX_W + 1)'(N_OBJ);
    localparam logic [IDX_W:0] N_MIN = (IDX_W + 1)'(2);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d, addr_q, addr_d;
    logic [IDX_W-1:0] hit_i_q, hit_j_q;
    logic [IDX_W:0]   n_q, n_d, n_clamp;
    logic [15:0]      cnt_q;
    obj_t             obj_a_q, obj_b_q;

    logic cap_a, cap_b, take_hit, clr_cnt;
    logic is_collision, pair_hit;

    // Next pair selection shared by CHECK (no hit) and EMIT (accepted)
    scan_state_t      adv_state;
    logic [IDX_W-1:0] adv_i, adv_j, adv_addr, i_inc1;
    logic [IDX_W:0]   j_inc, i_inc2;

    collision_detector u_detector (
        .obj_a        (obj_a_q),
        .obj_b        (obj_b_q),
        .is_collision (is_collision)
    );

`ifdef COLL_SCAN_SKIP_STATIC_EN
    logic both_static;
    assign both_static = (obj_a_q.vel.x == '0) && (obj_a_q.vel.y == '0) &&
                         (obj_b_q.vel.x == '0) && (obj_b_q.vel.y == '0);
    assign pair_hit = is_collision && !both_static;
`else
    assign pair_hit = is_collision;
`endif

    assign n_clamp = (num_objects > N_MAX) ? N_MAX : num_objects;
    assign j_inc   = {1'b0, j_q} + (IDX_W + 1)'(1);
    assign i_inc2  = {1'b0, i_q} + (IDX_W + 1)'(2);
    assign i_inc1  = i_q + IDX_W'(1);

    always_comb begin
        adv_state = ST_DONE;
        adv_i     = i_q;
        adv_j     = j_q;
        adv_addr  = addr_q;
        if (j_inc < n_q) begin
            adv_state = ST_RD_B;
            adv_j     = j_inc[IDX_W-1:0];
            adv_addr  = j_inc[IDX_W-1:0];
        end else if (i_inc2 < n_q) begin
            adv_state = ST_RD_A;
            adv_i     = i_inc1;
            adv_j     = i_inc2[IDX_W-1:0];
            adv_addr  = i_inc1;
        end
    end

    // The read address is a register loaded on the transition into each
    // RD/REG_A state, so it holds its last value everywhere else.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        n_d      = n_q;
        addr_d   = addr_q;
        cap_a    = 1'b0;
        cap_b    = 1'b0;
        take_hit = 1'b0;
        clr_cnt  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = n_clamp;
                    clr_cnt = 1'b1;
                    if (n_clamp < N_MIN) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = '0;
                        j_d     = IDX_W'(1);
                        addr_d  = '0;
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                addr_d  = j_q;
                state_d = ST_REG_A;
            end
            ST_REG_A: begin
                cap_a   = 1'b1;
                state_d = ST_REG_B;
            end
            ST_RD_B: begin
                state_d = ST_REG_B;
            end
            ST_REG_B: begin
                cap_b   = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (pair_hit) begin
                    take_hit = 1'b1;
                    state_d  = ST_EMIT;
                end else begin
                    state_d = adv_state;
                    i_d     = adv_i;
                    j_d     = adv_j;
                    addr_d  = adv_addr;
                end
            end
            ST_EMIT: begin
                if (hit_ready) begin
                    state_d = adv_state;
                    i_d     = adv_i;
                    j_d     = adv_j;
                    addr_d  = adv_addr;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obj_a_q <= '0;
            obj_b_q <= '0;
        end else begin
            if (cap_a) obj_a_q <= obj_t'(obj_rd_data);
            if (cap_b) obj_b_q <= obj_t'(obj_rd_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_i_q <= '0;
            hit_j_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (take_hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (take_hit) begin
                hit_i_q <= i_q;
                hit_j_q <= j_q;
            end
        end
    end

    assign obj_rd_addr = addr_q;
    assign hit_valid   = (state_q == ST_EMIT);
    assign hit_i       = hit_i_q;
    assign hit_j       = hit_j_q;
    assign hit_count   = cnt_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_collision_pair_scanner.sv
`timescale 1ns/1ps
module tb_collision_pair_scanner;
    import physics_pkg::*;

    localparam int N_OBJ = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_objects = '0;
    logic [IDX_W-1:0] obj_rd_addr;
    logic [OBJ_W-1:0] obj_rd_data = '0;
    logic             hit_valid;
    logic             hit_ready = 1'b0;
    logic [IDX_W-1:0] hit_i, hit_j;
    logic [15:0]      hit_count;
    logic             busy, done;

    obj_t mem [N_OBJ];

    int n_tests = 0;
    int n_fail  = 0;

    int cyc;
    int nhits;
    logic [IDX_W-1:0] addr_log [$];
    logic [IDX_W-1:0] exp_i [$];
    logic [IDX_W-1:0] exp_j [$];

    always #5 clk = ~clk;

    // Synchronous-read object RAM
    always @(posedge clk) obj_rd_data <= mem[obj_rd_addr];

    collision_pair_scanner #(.N_OBJ(N_OBJ)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_objects (num_objects),
        .obj_rd_addr (obj_rd_addr),
        .obj_rd_data (obj_rd_data),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_i       (hit_i),
        .hit_j       (hit_j),
        .hit_count   (hit_count),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // 16x16 unrotated box at (px,py), vel.x = vx
    function automatic obj_t mk_obj(input int px, input int py, input int vx);
        obj_t o;
        o        = '0;
        o.width  = 8'd16;
        o.height = 8'd16;
        o.pos.x  = px * (1 << 25);
        o.pos.y  = py * (1 << 25);
        o.vel.x  = vx * (1 << 26);
        o.u.x    = 16'sd16384;
        o.v.y    = 16'sd16384;
        return o;
    endfunction

    // Starts a scan, serves the hit port with `stall` low-ready cycles per
    // hit, optionally pulses start again in cycle `poke`. Cycle 1 is the
    // cycle after the edge that samples start.
    task automatic run_scan(input int n, input int stall, input int poke);
        int wait_cnt;
        int extra;
        addr_log.delete();
        nhits    = 0;
        cyc      = 0;
        wait_cnt = 0;
        hit_ready = (stall == 0);
        @(negedge clk);
        start       = 1'b1;
        num_objects = (IDX_W + 1)'(n);
        @(posedge clk);
        #1 start = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            start = (poke != 0) && (cyc == poke);
            addr_log.push_back(obj_rd_addr);
            if (done) break;
            if (cyc >= 3000) begin
                check("done_seen", done, 1);
                break;
            end
            if (!hit_valid) begin
                wait_cnt  = 0;
                hit_ready = (stall == 0);
            end else begin
                if (nhits < exp_i.size())
                    check("hit_pair", {hit_i, hit_j}, {exp_i[nhits], exp_j[nhits]});
                else
                    check("unexpected_hit", nhits, exp_i.size());
                check("hit_count_emit", hit_count, nhits + 1);
                if (wait_cnt >= stall) begin
                    hit_ready = 1'b1;
                    nhits++;
                end else begin
                    hit_ready = 1'b0;
                    wait_cnt++;
                end
            end
        end
        start = 1'b0;
        extra = 0;
        @(negedge clk);
        check("busy_after_done", busy, 0);
        if (done) extra++;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("extra_done", extra, 0);
    endtask

    initial begin
        int guard;
        int k;
        logic [IDX_W-1:0] ea [$];

        for (int m = 0; m < N_OBJ; m++) mem[m] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {hit_valid, busy, done, hit_i, hit_j, obj_rd_addr, hit_count}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // 1: two overlapping boxes -> one hit, done in cycle 6
        mem[0] = mk_obj(10, 10, 1);
        mem[1] = mk_obj(20, 10, 1);
        exp_i = {3'd0}; exp_j = {3'd1};
        run_scan(2, 0, 0);
        check("t1_done_cycle", cyc, 6);
        check("t1_nhits", nhits, 1);
        check("t1_hit_count", hit_count, 1);

        // 4: three mutually overlapping boxes, 5-cycle stall per hit
        mem[0] = mk_obj(10, 10, 1);
        mem[1] = mk_obj(14, 10, 1);
        mem[2] = mk_obj(18, 10, 1);
        exp_i = {3'd0, 3'd0, 3'd1}; exp_j = {3'd1, 3'd2, 3'd2};
        run_scan(3, 5, 0);
        check("t4_done_cycle", cyc, 30);
        check("t4_nhits", nhits, 3);
        check("t4_hit_count", hit_count, 3);

        // 2: separated pair -> no hit, count cleared, done in cycle 5
        mem[0] = mk_obj(10, 10, 1);
        mem[1] = mk_obj(40, 10, 1);
        exp_i.delete(); exp_j.delete();
        run_scan(2, 0, 0);
        check("t2_done_cycle", cyc, 5);
        check("t2_nhits", nhits, 0);
        check("t2_hit_count", hit_count, 0);

        // 3: eight distant objects -> 28 pairs, address sequence, cycle 92
        for (int m = 0; m < N_OBJ; m++)
            mem[m] = mk_obj(-60 + 40 * (m % 4), (m < 4) ? -30 : 30, 1);
        ea.delete();
        for (int i = 0; i < N_OBJ - 1; i++) begin
            ea.push_back(IDX_W'(i));
            repeat (3) ea.push_back(IDX_W'(i + 1));
            for (int j = i + 2; j < N_OBJ; j++) repeat (3) ea.push_back(IDX_W'(j));
        end
        ea.push_back(IDX_W'(N_OBJ - 1));
        run_scan(8, 0, 0);
        check("t3_done_cycle", cyc, 92);
        check("t3_nhits", nhits, 0);
        check("t3_addr_len", addr_log.size(), ea.size());
        k = (addr_log.size() < ea.size()) ? addr_log.size() : ea.size();
        for (int c = 0; c < k; c++) check($sformatf("t3_addr_c%0d", c + 1), addr_log[c], ea[c]);

        // num_objects above N_OBJ clamps to N_OBJ
        run_scan(12, 0, 0);
        check("clamp_done_cycle", cyc, 92);

        // Counts below 2 finish immediately
        run_scan(1, 0, 0);
        check("n1_done_cycle", cyc, 1);
        check("n1_hit_count", hit_count, 0);
        run_scan(0, 0, 0);
        check("n0_done_cycle", cyc, 1);

        // 5a: reset asserted during EMIT
        mem[0] = mk_obj(10, 10, 1);
        mem[1] = mk_obj(20, 10, 1);
        hit_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; num_objects = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (!hit_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t5_emit_reached", hit_valid, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_outputs", {hit_valid, busy, done, hit_i, hit_j, obj_rd_addr, hit_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_i = {3'd0}; exp_j = {3'd1};
        run_scan(2, 0, 0);
        check("t5_rescan_done_cycle", cyc, 6);
        check("t5_rescan_nhits", nhits, 1);

        // 5b: start pulsed while busy is dropped
        for (int m = 0; m < N_OBJ; m++)
            mem[m] = mk_obj(-60 + 40 * (m % 4), (m < 4) ? -30 : 30, 1);
        exp_i.delete(); exp_j.delete();
        run_scan(8, 0, 20);
        check("t5_busy_start_done_cycle", cyc, 92);

        // 6: overlapping pair with zero velocities
        mem[0] = mk_obj(10, 10, 0);
        mem[1] = mk_obj(20, 10, 0);
`ifdef COLL_SCAN_SKIP_STATIC_EN
        exp_i.delete(); exp_j.delete();
        run_scan(2, 0, 0);
        check("t6_static_done_cycle", cyc, 5);
        check("t6_static_hit_count", hit_count, 0);
        mem[0] = mk_obj(10, 10, 1);
        exp_i = {3'd0}; exp_j = {3'd1};
        run_scan(2, 0, 0);
        check("t6_moving_done_cycle", cyc, 6);
        check("t6_moving_hit_count", hit_count, 1);
`else
        exp_i = {3'd0}; exp_j = {3'd1};
        run_scan(2, 0, 0);
        check("t6_static_done_cycle", cyc, 6);
        check("t6_static_hit_count", hit_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
